// File: rtl/pe_border_serial_if.sv
// Bus bundle for the border PE: operand/control inputs and forwarded/result outputs.
// When PE_BORDER_SAT_EN is defined the bundle also carries sat_flag.
interface pe_border_serial_if #(
  parameter int IWIDTH = 8,
  parameter int IDEPTH = 4,
  parameter int OWIDTH = 24
);
  logic              en_i, clr_i, en_w, clr_w, en_o, clr_o, signed_mode;
  logic [IWIDTH-1:0] ifm, wght;
  logic [OWIDTH-1:0] ofm;
  logic [IWIDTH-1:0] ifm_d, wght_d;
  logic [OWIDTH-1:0] ofm_d;
  logic [IDEPTH-1:0] idx_d;
  logic              en_i_d, clr_i_d, en_w_d, clr_w_d, en_o_d, clr_o_d;
  logic              busy, mac_done;
`ifdef PE_BORDER_SAT_EN
  logic              sat_flag;
`endif

  modport master (
`ifdef PE_BORDER_SAT_EN
    input  sat_flag,
`endif
    output en_i, clr_i, en_w, clr_w, en_o, clr_o, signed_mode, ifm, wght, ofm,
    input  ifm_d, wght_d, ofm_d, idx_d, en_i_d, clr_i_d, en_w_d, clr_w_d,
    input  en_o_d, clr_o_d, busy, mac_done
  );

  modport slave (
`ifdef PE_BORDER_SAT_EN
    output sat_flag,
`endif
    input  en_i, clr_i, en_w, clr_w, en_o, clr_o, signed_mode, ifm, wght, ofm,
    output ifm_d, wght_d, ofm_d, idx_d, en_i_d, clr_i_d, en_w_d, clr_w_d,
    output en_o_d, clr_o_d, busy, mac_done
  );
endinterface

// File: rtl/pe_border_serial.sv
// Left-column systolic PE: digit-serial shift-add multiply (BPC bits/cycle) then accumulate.
// Optional PE_BORDER_SAT_EN: saturating accumulate with a sat_flag pulse.
module pe_border_serial #(
  parameter int IWIDTH = 8,
  parameter int BPC    = 1,
  parameter int IDEPTH = 4,
  parameter int OWIDTH = 24
) (
  input  logic               clk,
  input  logic               rst,
  pe_border_serial_if.slave  bus
);
  localparam int N  = IWIDTH / BPC;
  localparam int PW = 2 * IWIDTH;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_ACC} state_t;

  state_t            r_state, w_state_next;
  logic [IWIDTH-1:0] r_ifm, r_wght, r_a, r_b;
  logic              r_sgn;
  logic [PW-1:0]     r_prod;
  logic [IDEPTH-1:0] r_cnt, r_idx;
  logic [OWIDTH-1:0] r_ofm;
  logic              r_done, r_sat;
  logic [5:0]        r_ctl;

  logic              w_last, w_dneg, w_sat;
  logic [IWIDTH-1:0] w_bsh;
  logic [BPC-1:0]    w_digit;
  logic [PW-1:0]     w_a_ext, w_d_ext, w_mul, w_pp;
  logic [OWIDTH-1:0] w_prod_ext, w_sum;

  assign w_last  = (r_cnt == IDEPTH'(N - 1));
  assign w_bsh   = r_b >> (r_cnt * BPC);
  assign w_digit = w_bsh[BPC-1:0];
  // In signed mode the top multiplier digit is itself signed, giving the MSB weight -2^(IWIDTH-1).
  assign w_dneg  = r_sgn & w_last & w_digit[BPC-1];
  assign w_a_ext = {{IWIDTH{r_sgn & r_a[IWIDTH-1]}}, r_a};
  assign w_d_ext = {{(PW-BPC){w_dneg}}, w_digit};
  assign w_mul   = w_a_ext * w_d_ext;
  assign w_pp    = w_mul << (r_cnt * BPC);

  assign w_prod_ext = r_sgn ? OWIDTH'($signed(r_prod)) : OWIDTH'(r_prod);

`ifdef PE_BORDER_SAT_EN
  logic [OWIDTH:0] w_sum_wide;
  always_comb begin
    w_sum_wide = r_sgn ? ({bus.ofm[OWIDTH-1], bus.ofm} + {w_prod_ext[OWIDTH-1], w_prod_ext})
                       : ({1'b0, bus.ofm} + {1'b0, w_prod_ext});
    w_sat      = r_sgn ? (w_sum_wide[OWIDTH] ^ w_sum_wide[OWIDTH-1]) : w_sum_wide[OWIDTH];
    w_sum      = w_sum_wide[OWIDTH-1:0];
    if (w_sat) begin
      if (!r_sgn)                  w_sum = '1;
      else if (w_sum_wide[OWIDTH]) w_sum = {1'b1, {(OWIDTH-1){1'b0}}};
      else                         w_sum = {1'b0, {(OWIDTH-1){1'b1}}};
    end
  end
  assign bus.sat_flag = r_sat;
`else
  assign w_sum = bus.ofm + w_prod_ext;
  assign w_sat = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.en_o) w_state_next = S_MUL;
      S_MUL:   if (w_last)   w_state_next = S_ACC;
      S_ACC:                 w_state_next = S_IDLE;
      default:               w_state_next = S_IDLE;
    endcase
    if (bus.clr_o) w_state_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ifm <= '0; r_wght <= '0; r_a <= '0; r_b <= '0; r_sgn <= 1'b0;
      r_prod <= '0; r_cnt <= '0; r_idx <= '0; r_ofm <= '0;
      r_done <= 1'b0; r_sat <= 1'b0; r_ctl <= '0;
    end else begin
      r_ctl  <= {bus.en_i, bus.clr_i, bus.en_w, bus.clr_w, bus.en_o, bus.clr_o};
      if (bus.clr_i)     r_ifm  <= '0;
      else if (bus.en_i) r_ifm  <= bus.ifm;
      if (bus.clr_w)     r_wght <= '0;
      else if (bus.en_w) r_wght <= bus.wght;
      r_done <= 1'b0;
      r_sat  <= 1'b0;
      if (bus.clr_o) begin
        r_ofm  <= '0;
        r_prod <= '0;
        r_cnt  <= '0;
      end else begin
        case (r_state)
          S_IDLE: if (bus.en_o) begin
            r_a    <= r_ifm;
            r_b    <= r_wght;
            r_sgn  <= bus.signed_mode;
            r_prod <= '0;
            r_cnt  <= '0;
          end
          S_MUL: begin
            r_prod <= r_prod + w_pp;
            r_idx  <= r_cnt;
            r_cnt  <= r_cnt + 1'b1;
          end
          S_ACC: begin
            r_ofm  <= w_sum;
            r_done <= 1'b1;
            r_sat  <= w_sat;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.ifm_d    = r_ifm;
  assign bus.wght_d   = r_wght;
  assign bus.ofm_d    = r_ofm;
  assign bus.idx_d    = r_idx;
  assign bus.busy     = (r_state == S_MUL);
  assign bus.mac_done = r_done;
  assign {bus.en_i_d, bus.clr_i_d, bus.en_w_d, bus.clr_w_d, bus.en_o_d, bus.clr_o_d} = r_ctl;
endmodule

// File: doc/pe_border_serial.md
Name: pe_border_serial

Overview:
- Next-generation left-column (border) PE for the binary-serial systolic array.
- Holds an input-feature register and a weight register.
- Computes the full-precision product with a multi-cycle shift-add multiplier that consumes BPC multiplier bits per cycle, then adds the product to the incoming partial sum.
- Forwards operands, controls and the digit index to the neighbouring PEs.
- Supports a runtime signed/unsigned mode and a busy/done handshake.

Parameters:
- IWIDTH, 8: operand width (ifm, wght).
- BPC, 1: multiplier bits consumed per cycle; must divide IWIDTH. N = IWIDTH/BPC multiply cycles.
- IDEPTH, 4: width of the digit index; must satisfy 2^IDEPTH >= N.
- OWIDTH, 24: partial-sum width; must satisfy OWIDTH >= 2*IWIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- en_i  in  1  load ifm register
- clr_i  in  1  clear ifm register
- en_w  in  1  load weight register
- clr_w  in  1  clear weight register
- en_o  in  1  start MAC request
- clr_o  in  1  clear/abort accumulate path
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned
- ifm  in  IWIDTH  input feature
- wght  in  IWIDTH  weight
- ofm  in  OWIDTH  incoming partial sum
- ifm_d  out  IWIDTH  registered ifm, forwarded east
- wght_d  out  IWIDTH  registered weight, forwarded south
- ofm_d  out  OWIDTH  result partial sum
- idx_d  out  IDEPTH  current digit index, forwarded
- en_i_d, clr_i_d, en_w_d, clr_w_d, en_o_d, clr_o_d  out  1 each  controls delayed 1 cycle
- busy  out  1  multiply in progress
- mac_done  out  1  1-cycle pulse, ofm_d updated

Behaviour:
- Reset: all outputs and all internal state go to 0; FSM enters IDLE. Reset is honoured mid-multiply; no mac_done is produced.
- Operand registers:
  - clr has priority over en.
  - ifm_d <= clr_i ? 0 : en_i ? ifm : hold.
  - wght_d follows the same rule with clr_w/en_w.
- Control forwarding: every *_d control is its input delayed by exactly 1 cycle, independent of FSM state.
- FSM states: IDLE, MUL, ACC.
  - IDLE:
    - en_o=1 and clr_o=0 → capture A=ifm_d, B=wght_d and signed_mode into internal copies.
    - Clear the product register, set cnt=0, go to MUL. busy=1 from the next cycle.
  - MUL:
    - Each cycle add (A × B[cnt*BPC +: BPC]) << (cnt*BPC) into a 2*IWIDTH product register.
    - Signed mode: A is sign-extended to 2*IWIDTH. On the last digit (cnt=N-1) the top multiplier bit carries weight -2^(IWIDTH-1), so the partial product for that bit is subtracted.
    - idx_d <= cnt; cnt increments each cycle.
    - After the digit with cnt=N-1 is processed, go to ACC.
  - ACC (1 cycle):
    - ofm_d <= ofm + ext(prod), where ext is sign-extension in signed mode and zero-extension otherwise.
    - mac_done=1 for this cycle only; busy=0 afterwards; return to IDLE.
- Latency: en_o sampled at cycle 0 → ofm_d valid and mac_done high at cycle N+1. Back-to-back throughput is one MAC per N+2 cycles.
- en_o while busy: ignored; no queuing.
- Operand register changes during MUL do not affect the in-flight product.
- clr_o (highest priority for the accumulate path, any state): ofm_d <= 0, FSM → IDLE, product cleared, no mac_done. This also aborts a MUL in progress.
- en_o and clr_o high together: clr_o wins.
- ofm is sampled in the ACC cycle only and must be stable then.
- Overflow of ofm + prod wraps modulo 2^OWIDTH unless PE_BORDER_SAT_EN is defined.
- idx_d holds its last value outside MUL and resets to 0.

Optional Feature:
- Macro: PE_BORDER_SAT_EN.
- Defined: the ACC sum is computed in OWIDTH+1 bits and saturates.
  - Signed mode: clamp to [-2^(OWIDTH-1), 2^(OWIDTH-1)-1].
  - Unsigned mode: clamp to 2^OWIDTH-1.
  - An extra output sat_flag (1 bit) pulses with mac_done when clamping occurred.
- Undefined: the result wraps modulo 2^OWIDTH and the sat_flag port is absent.

Test Plan:
- IWIDTH=8, BPC=1, signed_mode=1; load ifm=-3, wght=5, ofm=100; pulse en_o → busy for 8 cycles; mac_done at cycle 9; ofm_d=85; idx_d steps 0..7.
- Same operands with signed_mode=0 (ifm=0xFD=253, wght=5, ofm=0) → ofm_d=1265. Signed -128 × -128 with ofm=0 → 16384.
- BPC=2 (N=4): ifm=7, wght=-2, ofm=0, signed → ofm_d=-14 with mac_done at cycle 5. An en_o pulse at cycle 2 is ignored, so exactly one mac_done occurs.
- clr_o asserted at cycle 3 of a MUL → ofm_d=0 next cycle, busy=0, no mac_done. Asserting rst mid-MUL → all outputs 0 immediately (asynchronous), no mac_done.
- Overflow: ofm=2^23-1, ifm=1, wght=1, signed:
  - without PE_BORDER_SAT_EN → ofm_d=-2^23;
  - with it → ofm_d=2^23-1 and sat_flag=1.
- Forwarding: random en_i/clr_i/en_w/clr_w/en_o/clr_o streams → each *_d equals its input delayed 1 cycle. clr_i and en_i high together → ifm_d=0.
